// File: rtl/wave_phase_gen_pkg.sv
// ---------------------------------------------------------------------------
// wave_phase_gen_pkg
//   Shared audio-path definitions used by the phase generator, the wavetable
//   ROM stages and the mixer.
//   - Gate FSM state encoding.
//   - RAMP_W: width of the wavetable index (64-entry table).
//   - Default accumulator / step / volume widths, so all stages agree.
//   - Control struct passed from the gate FSM to the phase accumulator.
// ---------------------------------------------------------------------------
package wave_phase_gen_pkg;

  localparam int RAMP_W        = 6;
  localparam int DEF_ACC_W     = 20;
  localparam int DEF_STEP_W    = 16;
  localparam int DEF_VOL_W     = 8;
  localparam int DEF_DECAY_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SUSTAIN = 2'd1,
    ST_RELEASE = 2'd2
  } wpg_state_e;

  // Accumulator command for one clock: clr wins over adv.
  typedef struct packed {
    logic clr;
    logic adv;
  } acc_ctrl_t;

  // Width of the release divider counter; a divide-by-1 still needs one bit.
  function automatic int div_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/wave_phase_acc.sv
// ---------------------------------------------------------------------------
// wave_phase_acc
//   Phase accumulator plus frequency step register for one voice.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     note_wr      load note_step into the step register (takes effect on
//                  the following cycle)
//     note_step    phase increment per advance
//     ctrl         {clr, adv} from the gate FSM; clr has priority
//     acc_nxt      next-state accumulator value (what the register is about
//                  to take), so the caller can register a tap of it with the
//                  same latency as the accumulator itself
// ---------------------------------------------------------------------------
module wave_phase_acc
  import wave_phase_gen_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              note_wr,
  input  logic [STEP_W-1:0] note_step,
  input  acc_ctrl_t         ctrl,
  output logic [ACC_W-1:0]  acc_nxt
);

  logic [STEP_W-1:0] step_q, step_d;
  logic [ACC_W-1:0]  acc_q,  acc_d;

  // The adder always sees the already-registered step, so a note_wr in the
  // same cycle as an advance only affects the next advance.
  always_comb begin
    step_d = note_wr ? note_step : step_q;
    acc_d  = acc_q;
    if (ctrl.clr)
      acc_d = '0;
    else if (ctrl.adv)
      acc_d = acc_q + ACC_W'(step_q);   // modulo 2^ACC_W wrap
  end

  assign acc_nxt = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      acc_q  <= '0;
    end else begin
      step_q <= step_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/wave_phase_gen.sv
// ---------------------------------------------------------------------------
// wave_phase_gen
//   Per-voice phase/gate generator feeding the 64-entry wavetable ROM.
//   Advances a phase accumulator on each audio sample strobe, exposes its top
//   RAMP_W bits as the table index, and runs a key-on/key-off gate with a
//   linear release of the output volume.
//   Ports:
//     clk, rst_n   clock, async active-low reset (outputs clear immediately)
//     sample_en    one-cycle audio sample strobe
//     note_wr      load note_step into the step register
//     note_step    phase increment per sample
//     key_on       start / retrigger note (beats key_off and sample_en)
//     key_off      begin release (only honoured in SUSTAIN)
//     ramp         registered wavetable index, 1 clk after the strobe
//     volume       registered envelope level, all ones = full scale
//     active       high in SUSTAIN or RELEASE
// ---------------------------------------------------------------------------
module wave_phase_gen
  import wave_phase_gen_pkg::*;
#(
  parameter int ACC_W     = DEF_ACC_W,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int VOL_W     = DEF_VOL_W,
  parameter int DECAY_DIV = DEF_DECAY_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              note_wr,
  input  logic [STEP_W-1:0] note_step,
  input  logic              key_on,
  input  logic              key_off,
  output logic [RAMP_W-1:0] ramp,
  output logic [VOL_W-1:0]  volume,
  output logic              active
);

  localparam int               DIV_W    = div_cnt_w(DECAY_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam logic [VOL_W-1:0] VOL_FULL = {VOL_W{1'b1}};
  localparam logic [VOL_W-1:0] VOL_ONE  = VOL_W'(1);

  wpg_state_e        state_q, state_d;
  logic [VOL_W-1:0]  vol_q,   vol_d;
  logic [DIV_W-1:0]  div_q,   div_d;
  logic [RAMP_W-1:0] ramp_q,  ramp_d;
  logic              active_q, active_d;

  acc_ctrl_t         acc_ctrl;
  logic [ACC_W-1:0]  acc_nxt;

  wave_phase_acc #(
    .ACC_W  (ACC_W),
    .STEP_W (STEP_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .note_wr   (note_wr),
    .note_step (note_step),
    .ctrl      (acc_ctrl),
    .acc_nxt   (acc_nxt)
  );

  // Gate FSM and release envelope.
  always_comb begin
    state_d  = state_q;
    vol_d    = vol_q;
    div_d    = div_q;
    acc_ctrl = '0;

    if (key_on) begin
      // Retrigger from any state restarts phase and envelope together.
      state_d      = ST_SUSTAIN;
      vol_d        = VOL_FULL;
      div_d        = '0;
      acc_ctrl.clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SUSTAIN: begin
          acc_ctrl.adv = sample_en;
          if (key_off) begin
            state_d = ST_RELEASE;
            div_d   = '0;
          end
        end
        ST_RELEASE: begin
          if (sample_en) begin
            acc_ctrl.adv = 1'b1;
            if (div_q == DIV_LAST) begin
              div_d = '0;
              vol_d = vol_q - VOL_ONE;
              // Last step of the release: drop to IDLE and park the phase at
              // 0 so the table reads its silent entry.
              if (vol_q == VOL_ONE) begin
                state_d      = ST_IDLE;
                acc_ctrl.clr = 1'b1;
                acc_ctrl.adv = 1'b0;
              end
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;   // unused encoding recovers to IDLE
      endcase
    end

    // Index follows the accumulator value being written this cycle.
    ramp_d   = acc_nxt[ACC_W-1 -: RAMP_W];
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vol_q    <= '0;
      div_q    <= '0;
      ramp_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vol_q    <= vol_d;
      div_q    <= div_d;
      ramp_q   <= ramp_d;
      active_q <= active_d;
    end
  end

  assign ramp   = ramp_q;
  assign volume = vol_q;
  assign active = active_q;

endmodule

// File: tb/tb_wave_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_wave_phase_gen
//   Directed stimulus for wave_phase_gen with default parameters
//   (ACC_W=20, STEP_W=16, VOL_W=8, DECAY_DIV=4). Each driven cycle pushes
//   the expected post-edge outputs into a queue; a monitor pops one entry
//   per clock and compares. A ramp or volume of -1 means "don't check".
// ---------------------------------------------------------------------------
module tb_wave_phase_gen;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic        note_wr;
  logic [15:0] note_step;
  logic        key_on;
  logic        key_off;
  logic [5:0]  ramp;
  logic [7:0]  volume;
  logic        active;

  wave_phase_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .note_wr   (note_wr),
    .note_step (note_step),
    .key_on    (key_on),
    .key_off   (key_off),
    .ramp      (ramp),
    .volume    (volume),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    er;
    int    ev;
    bit    ea;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
    end
  endfunction

  // Monitor: one expected entry per driven clock edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.er >= 0) chk({e.nm, " ramp"}, int'(ramp), e.er);
      if (e.ev >= 0) begin
        chk({e.nm, " volume"}, int'(volume), e.ev);
        chk({e.nm, " active"}, int'(active), int'(e.ea));
      end
    end
  end

  // Drive one clock of inputs and queue the outputs expected after the edge.
  task automatic step(input bit se, input bit wr, input logic [15:0] st,
                      input bit kon, input bit koff,
                      input int er, input int ev, input bit ea, input string nm);
    exp_t x;
    @(negedge clk);
    sample_en = se;
    note_wr   = wr;
    note_step = st;
    key_on    = kon;
    key_off   = koff;
    x.er = er; x.ev = ev; x.ea = ea; x.nm = nm;
    exp_q.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; sample_en = 0; note_wr = 0; note_step = '0; key_on = 0; key_off = 0;
    #1;
    chk("reset ramp", int'(ramp), 0);
    chk("reset volume", int'(volume), 0);
    chk("reset active", int'(active), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0, "idle strobe");

    // Step 0x4000 = one table index per strobe; wraps 63->0 at strobe 64.
    step(0, 1, 16'h4000, 0, 0, 0, 0, 0, "load step");
    step(0, 0, 0, 1, 0, 0, 'hFF, 1, "key_on");
    for (int k = 1; k <= 70; k++) begin
      step(1, 0, 0, 0, 0, k % 64, 'hFF, 1, "sustain 4000");
      step(0, 0, 0, 0, 0, k % 64, 'hFF, 1, "hold no strobe");
    end

    // Step 0x2000 = half an index per strobe; switch to 0x8000 mid-note.
    step(0, 1, 16'h2000, 0, 0, 6, 'hFF, 1, "load 2000");
    step(0, 0, 0, 1, 0, 0, 'hFF, 1, "retrigger");
    for (int k = 1; k <= 6; k++)
      step(1, 0, 0, 0, 0, k / 2, 'hFF, 1, "sustain 2000");
    // Strobe 7 still uses 0x2000: acc = 0xE000, ramp 3.
    step(1, 1, 16'h8000, 0, 0, 3, 'hFF, 1, "step change strobe");
    for (int j = 1; j <= 4; j++)
      step(1, 0, 0, 0, 0, 3 + 2 * j, 'hFF, 1, "sustain 8000");

    // Full release: 255*4 = 1020 strobes from key_off to IDLE.
    step(0, 1, 16'h4000, 1, 0, 0, 'hFF, 1, "retrigger 4000");
    for (int k = 1; k <= 3; k++)
      step(1, 0, 0, 0, 0, k, 'hFF, 1, "pre-release");
    step(0, 0, 0, 0, 1, 3, 'hFF, 1, "key_off");
    for (int n = 1; n <= 1020; n++) begin
      if (n < 1020)
        step(1, 0, 0, 0, 0, (3 + n) % 64, 255 - n / 4, 1, "release");
      else
        step(1, 0, 0, 0, 0, 0, 0, 0, "release end");
    end
    step(0, 0, 0, 0, 1, 0, 0, 0, "key_off in idle");
    step(1, 0, 0, 0, 0, 0, 0, 0, "strobe in idle");

    // Release down to 0x40, then key_on+key_off+strobe together.
    step(0, 0, 0, 1, 0, 0, 'hFF, 1, "key_on 2");
    step(0, 0, 0, 0, 1, 0, 'hFF, 1, "key_off 2");
    for (int n = 1; n <= 764; n++)
      step(1, 0, 0, 0, 0, n % 64, 255 - n / 4, 1, "release to 40");
    step(1, 0, 0, 1, 1, 0, 'hFF, 1, "on+off in release");

    // Second key_off in RELEASE must not restart the divider.
    step(0, 0, 0, 0, 1, 0, 'hFF, 1, "key_off 3");
    step(1, 0, 0, 0, 0, 1, 'hFF, 1, "rel strobe 1");
    step(1, 0, 0, 0, 0, 2, 'hFF, 1, "rel strobe 2");
    step(0, 0, 0, 0, 1, 2, 'hFF, 1, "repeat key_off");
    step(1, 0, 0, 0, 0, 3, 'hFF, 1, "rel strobe 3");
    step(1, 0, 0, 0, 0, 4, 'hFE, 1, "rel strobe 4");
    for (int c = 0; c < 1000; c++)
      step(0, 0, 0, 0, 0, 4, 'hFE, 1, "no strobe hold");

    // Async reset mid-note: outputs clear without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async rst ramp", int'(ramp), 0);
    chk("async rst volume", int'(volume), 0);
    chk("async rst active", int'(active), 0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, "post reset");
    step(1, 0, 0, 0, 0, 0, 0, 0, "post reset strobe");
    step(0, 0, 0, 0, 0, 0, 0, 0, "drain");

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_phase_gen.md
Name: wave_phase_gen

Overview:
- Per-voice phase/gate generator. Sits directly upstream of the 64-entry wavetable ROM stages.
- Converts a programmed frequency step into the 6-bit `ramp` table index, advancing once per audio sample strobe.
- Runs a key-on/key-off gate FSM and produces a linear-release volume, which the downstream mixer multiplies with the table sample.

Parameters:
- ACC_W, 20, phase accumulator width; `ramp` = acc[ACC_W-1 -: 6]; legal range 8..32
- STEP_W, 16, frequency step width; STEP_W <= ACC_W
- VOL_W, 8, volume width; full scale = all ones
- DECAY_DIV, 4, sample strobes per 1-LSB volume decrement in RELEASE; >= 1

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active low
- sample_en  in  1  one-cycle strobe at audio sample rate
- note_wr  in  1  load note_step into step register (any cycle)
- note_step  in  STEP_W  phase increment per sample
- key_on  in  1  one-cycle strobe: start or retrigger note
- key_off  in  1  one-cycle strobe: begin release
- ramp  out  6  wavetable index, registered
- volume  out  VOL_W  envelope level, registered
- active  out  1  high in SUSTAIN or RELEASE

Behaviour:
- Reset (async, rst_n=0):
  - acc=0, step_reg=0, state=IDLE, div_cnt=0
  - ramp=0, volume=0, active=0
  - Takes effect mid-note with no drain.
- step_reg:
  - Loads note_step on the cycle after note_wr=1.
  - Used by the next sample_en; no glitch to the current acc.
- FSM states: IDLE, SUSTAIN, RELEASE.
  - key_on in any state → SUSTAIN next cycle:
    - acc=0, volume=all ones, div_cnt=0
    - key_on has priority over a simultaneous key_off and sample_en in that cycle; acc is cleared, not advanced.
  - key_off in SUSTAIN → RELEASE, div_cnt=0.
  - key_off in IDLE or RELEASE: ignored.
  - RELEASE on each sample_en:
    - If div_cnt==DECAY_DIV-1: div_cnt=0 and volume decrements by 1.
    - Otherwise div_cnt increments.
    - When the decrement makes volume 0: state=IDLE, acc=0, ramp=0 in the same update.
- Phase accumulation:
  - On sample_en in SUSTAIN or RELEASE: acc <= acc + zero-extended step_reg, modulo 2^ACC_W (wrap silently, no saturation).
  - In IDLE: acc holds 0.
- ramp:
  - Registered copy of acc[ACC_W-1 -: 6], taken from the updated acc value.
  - Valid 1 cycle after the sample_en edge (latency 1 clk).
  - ramp=0 in IDLE, which selects the table's silent entry.
- active: = (state != IDLE), registered, same timing as the state.
- Without sample_en: acc, div_cnt, ramp and volume hold, except for key_on/key_off state effects.
- step_reg=0 in SUSTAIN: ramp is frozen; the release still decays volume.
- Release duration: (2^VOL_W-1)*DECAY_DIV sample strobes from key_off to IDLE.

Decomposition:
- Shared audio package holds:
  - FSM state encoding (ST_IDLE=2'd0, ST_SUSTAIN=2'd1, ST_RELEASE=2'd2)
  - RAMP_W=6 constant
  - default ACC_W/STEP_W/VOL_W, shared with the wavetable and mixer stages
- One natural sub-module: wave_phase_acc, the accumulator plus step register with enable, clear and wrap.
- FSM and volume/decay logic stay in the top module.

Test Plan:
- Reset → ramp=0, volume=0, active=0. Then assert rst_n=0 mid-SUSTAIN → all outputs 0 asynchronously, with no clk edge needed.
- note_wr step=0x4000, key_on, 70 sample_en → ramp = 0,1,2,…,63,0,1,… Wraps 63→0 after 64 strobes; volume=0xFF, active=1.
- step=0x2000 → ramp increments every 2nd strobe. Mid-note, note_wr 0x8000 → increments by 2 from the next strobe, no skipped update.
- key_off after sustain, DECAY_DIV=4 → volume 0xFF→0xFE after 4 strobes. Reaches 0 and IDLE (ramp=0, active=0) exactly 1020 strobes after key_off.
- key_on and key_off in the same cycle during RELEASE (volume=0x40) → SUSTAIN, volume=0xFF, ramp=0 on the next cycle.
- key_off in IDLE, and key_off twice in RELEASE → no state change and no volume jump. No sample_en for 1000 cycles → outputs constant.
